// File: rtl/rf_wb_arbiter.sv
// Write-back arbiter: two requesters share one register-file write port, plus a 32-cycle clear sweep.
// Define RF_WB_FIXED_PRIO_EN to make requester 0 win every tie instead of round-robin.
module rf_wb_arbiter (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Req0,
  input  logic [4:0]  Addr0,
  input  logic [31:0] Data0,
  output logic        Ack0,
  input  logic        Req1,
  input  logic [4:0]  Addr1,
  input  logic [31:0] Data1,
  output logic        Ack1,
  input  logic        Clr_Req,
  output logic        Clr_Busy,
  output logic [4:0]  Rf_W_Addr,
  output logic [31:0] Rf_W_Data,
  output logic        Rf_We,
  output logic [1:0]  Dbg_State
);

  // Handshake: a requester raises Req_k and holds Addr_k/Data_k until it sees
  // Ack_k, a one-cycle pulse that means the write has been issued to the file.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_CLEAR = 2'd2
  } state_t;

  state_t      r_state, w_state_nxt;
  logic [4:0]  r_cnt, w_cnt_nxt;
  logic        r_last, w_last_nxt;
  logic        r_ack0, r_ack1, r_we, r_busy;
  logic [4:0]  r_addr;
  logic [31:0] r_data;
  logic        w_ack0_nxt, w_ack1_nxt, w_we_nxt, w_busy_nxt;
  logic [4:0]  w_addr_nxt;
  logic [31:0] w_data_nxt;
  logic        w_elig0, w_elig1, w_pick1;

  // A request whose ack is on the outputs right now was already written.
  assign w_elig0 = Req0 & ~r_ack0;
  assign w_elig1 = Req1 & ~r_ack1;

`ifdef RF_WB_FIXED_PRIO_EN
  assign w_pick1 = w_elig1 & ~w_elig0;
`else
  assign w_pick1 = w_elig1 & (~w_elig0 | ~r_last);
`endif

  always_comb begin
    w_state_nxt = ST_IDLE;
    w_cnt_nxt   = r_cnt;
    w_last_nxt  = r_last;
    w_ack0_nxt  = 1'b0;
    w_ack1_nxt  = 1'b0;
    w_we_nxt    = 1'b1;
    w_addr_nxt  = 5'd0;
    w_data_nxt  = 32'd0;
    w_busy_nxt  = 1'b0;
    case (r_state)
      ST_CLEAR: begin
        // r_cnt is the address on the outputs; it wraps to 0 as the sweep ends.
        w_cnt_nxt = r_cnt + 5'd1;
        if (r_cnt != 5'd31) begin
          w_state_nxt = ST_CLEAR;
          w_busy_nxt  = 1'b1;
          w_we_nxt    = 1'b0;
          w_addr_nxt  = r_cnt + 5'd1;
        end
      end
      default: begin
        if (Clr_Req) begin
          w_state_nxt = ST_CLEAR;
          w_cnt_nxt   = 5'd0;
          w_busy_nxt  = 1'b1;
          w_we_nxt    = 1'b0;
        end else if (w_elig0 | w_elig1) begin
          w_state_nxt = ST_WRITE;
          w_last_nxt  = w_pick1;
          if (w_pick1) begin
            w_ack1_nxt = 1'b1;
            w_addr_nxt = Addr1;
            w_data_nxt = Data1;
          end else begin
            w_ack0_nxt = 1'b1;
            w_addr_nxt = Addr0;
            w_data_nxt = Data0;
          end
          w_we_nxt = (w_addr_nxt == 5'd0);
        end
      end
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= 5'd0;
      r_last  <= 1'b1;
      r_ack0  <= 1'b0;
      r_ack1  <= 1'b0;
      r_we    <= 1'b1;
      r_addr  <= 5'd0;
      r_data  <= 32'd0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_last  <= w_last_nxt;
      r_ack0  <= w_ack0_nxt;
      r_ack1  <= w_ack1_nxt;
      r_we    <= w_we_nxt;
      r_addr  <= w_addr_nxt;
      r_data  <= w_data_nxt;
      r_busy  <= w_busy_nxt;
    end
  end

  assign Ack0      = r_ack0;
  assign Ack1      = r_ack1;
  assign Rf_We     = r_we;
  assign Rf_W_Addr = r_addr;
  assign Rf_W_Data = r_data;
  assign Clr_Busy  = r_busy;
  assign Dbg_State = r_state;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Self-checking bench for rf_wb_arbiter: vector table, clear/reset sequences, random run vs. model.
module tb_rf_wb_arbiter;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        Req0 = 1'b0, Req1 = 1'b0, Clr_Req = 1'b0;
  logic [4:0]  Addr0 = 5'd0, Addr1 = 5'd0;
  logic [31:0] Data0 = 32'd0, Data1 = 32'd0;
  logic        Ack0, Ack1, Clr_Busy, Rf_We;
  logic [4:0]  Rf_W_Addr;
  logic [31:0] Rf_W_Data;
  logic [1:0]  Dbg_State;

  int n_tests = 0;
  int n_fail  = 0;

  rf_wb_arbiter dut (
    .Clk(Clk), .Reset(Reset),
    .Req0(Req0), .Addr0(Addr0), .Data0(Data0), .Ack0(Ack0),
    .Req1(Req1), .Addr1(Addr1), .Data1(Data1), .Ack1(Ack1),
    .Clr_Req(Clr_Req), .Clr_Busy(Clr_Busy),
    .Rf_W_Addr(Rf_W_Addr), .Rf_W_Data(Rf_W_Data), .Rf_We(Rf_We),
    .Dbg_State(Dbg_State)
  );

  always #5 Clk = ~Clk;

  // Reference model: expected outputs for the current cycle plus sweep position.
  logic        m_ack0, m_ack1, m_we, m_busy;
  logic [4:0]  m_addr;
  logic [31:0] m_data;
  int          m_clr_idx, m_last;
  logic        n_ack0, n_ack1, n_we, n_busy;
  logic [4:0]  n_addr;
  logic [31:0] n_data;
  int          n_clr_idx, n_last;

  logic [36:0] exp_q[$];

  task automatic model_reset();
    m_ack0 = 0; m_ack1 = 0; m_we = 1; m_busy = 0; m_addr = 0; m_data = 0;
    m_clr_idx = -1; m_last = 1;
  endtask

  task automatic model_next();
    bit e0, e1;
    int g;
    n_ack0 = 0; n_ack1 = 0; n_we = 1; n_busy = 0; n_addr = 0; n_data = 0;
    n_clr_idx = -1; n_last = m_last;
    if (m_clr_idx >= 0) begin
      if (m_clr_idx < 31) begin
        n_clr_idx = m_clr_idx + 1;
        n_busy = 1; n_we = 0; n_addr = 5'(n_clr_idx);
      end
    end else if (Clr_Req) begin
      n_clr_idx = 0; n_busy = 1; n_we = 0;
    end else begin
      e0 = Req0 && !m_ack0;
      e1 = Req1 && !m_ack1;
      g = -1;
      if (e0 && e1) begin
`ifdef RF_WB_FIXED_PRIO_EN
        g = 0;
`else
        g = (m_last == 0) ? 1 : 0;
`endif
      end else if (e0) g = 0;
      else if (e1) g = 1;
      if (g >= 0) begin
        n_last = g;
        n_addr = (g == 0) ? Addr0 : Addr1;
        n_data = (g == 0) ? Data0 : Data1;
        n_ack0 = (g == 0);
        n_ack1 = (g == 1);
        n_we   = (n_addr == 0);
      end
    end
  endtask

  task automatic tick();
    model_next();
    @(posedge Clk);
    #1;
    m_ack0 = n_ack0; m_ack1 = n_ack1; m_we = n_we; m_busy = n_busy;
    m_addr = n_addr; m_data = n_data; m_clr_idx = n_clr_idx; m_last = n_last;
  endtask

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, got, exp);
    end
  endtask

  task automatic chk_out(input string nm, input logic a0, input logic a1, input logic we,
                         input logic [4:0] ad, input logic [31:0] d, input logic busy);
    chk({nm, ".ack0"}, 32'(Ack0), 32'(a0));
    chk({nm, ".ack1"}, 32'(Ack1), 32'(a1));
    chk({nm, ".we"},   32'(Rf_We), 32'(we));
    chk({nm, ".busy"}, 32'(Clr_Busy), 32'(busy));
    if (!we || a0 || a1) begin
      chk({nm, ".addr"}, 32'(Rf_W_Addr), 32'(ad));
      chk({nm, ".data"}, Rf_W_Data, d);
    end
  endtask

  task automatic clear_inputs();
    Req0 = 0; Req1 = 0; Clr_Req = 0; Addr0 = 0; Addr1 = 0; Data0 = 0; Data1 = 0;
  endtask

  task automatic do_reset();
    Reset = 1;
    clear_inputs();
    model_reset();
    @(posedge Clk);
    @(posedge Clk);
    #1;
    Reset = 0;
  endtask

  typedef struct {
    logic r0; logic [4:0] a0; logic [31:0] d0;
    logic r1; logic [4:0] a1; logic [31:0] d1;
    logic clr;
    logic e_ack0, e_ack1, e_we; logic [4:0] e_addr; logic [31:0] e_data; logic e_busy;
  } vec_t;

  function automatic vec_t mk(logic r0, logic [4:0] a0, logic [31:0] d0,
                              logic r1, logic [4:0] a1, logic [31:0] d1,
                              logic ea0, logic ea1, logic ewe, logic [4:0] ead, logic [31:0] ed);
    vec_t v;
    v.r0 = r0; v.a0 = a0; v.d0 = d0; v.r1 = r1; v.a1 = a1; v.d1 = d1; v.clr = 0;
    v.e_ack0 = ea0; v.e_ack1 = ea1; v.e_we = ewe; v.e_addr = ead; v.e_data = ed; v.e_busy = 0;
    return v;
  endfunction

  vec_t tbl[12];

  initial begin
    tbl[0]  = mk(1, 5, 32'h1234_5678, 0, 0, 0,            1, 0, 0, 5, 32'h1234_5678);
    tbl[1]  = mk(1, 5, 32'h1234_5678, 0, 0, 0,            0, 0, 1, 0, 0);
    tbl[2]  = mk(0, 0, 0,             1, 0, 32'hAAAA_5555, 0, 1, 1, 0, 32'hAAAA_5555);
    tbl[3]  = mk(0, 0, 0,             1, 0, 32'hAAAA_5555, 0, 0, 1, 0, 0);
    tbl[4]  = mk(1, 3, 32'h3,         1, 4, 32'h4,        1, 0, 0, 3, 32'h3);
    tbl[5]  = mk(1, 3, 32'h3,         1, 4, 32'h4,        0, 1, 0, 4, 32'h4);
    tbl[6]  = mk(1, 3, 32'h3,         1, 4, 32'h4,        1, 0, 0, 3, 32'h3);
    tbl[7]  = mk(1, 3, 32'h3,         1, 4, 32'h4,        0, 1, 0, 4, 32'h4);
    tbl[8]  = mk(0, 0, 0,             0, 0, 0,            0, 0, 1, 0, 0);
    tbl[9]  = mk(1, 9, 32'h99,        1, 10, 32'hA0,      1, 0, 0, 9, 32'h99);
    tbl[10] = mk(0, 0, 0,             0, 0, 0,            0, 0, 1, 0, 0);
`ifdef RF_WB_FIXED_PRIO_EN
    tbl[11] = mk(1, 9, 32'h99,        1, 10, 32'hA0,      1, 0, 0, 9, 32'h99);
`else
    tbl[11] = mk(1, 9, 32'h99,        1, 10, 32'hA0,      0, 1, 0, 10, 32'hA0);
`endif

    do_reset();
    chk_out("reset", 0, 0, 1, 0, 0, 0);
    chk("reset.addr", 32'(Rf_W_Addr), 32'd0);
    chk("reset.data", Rf_W_Data, 32'd0);

    for (int i = 0; i < 12; i++) begin
      Req0 = tbl[i].r0; Addr0 = tbl[i].a0; Data0 = tbl[i].d0;
      Req1 = tbl[i].r1; Addr1 = tbl[i].a1; Data1 = tbl[i].d1;
      Clr_Req = tbl[i].clr;
      tick();
      chk_out($sformatf("vec%0d", i), tbl[i].e_ack0, tbl[i].e_ack1, tbl[i].e_we,
              tbl[i].e_addr, tbl[i].e_data, tbl[i].e_busy);
    end

    // Clear sweep with requester 0 waiting; a stray Clr_Req mid-sweep is ignored.
    clear_inputs();
    tick();
    Clr_Req = 1; Req0 = 1; Addr0 = 7; Data0 = 32'h77;
    tick();
    chk_out("clr0", 0, 0, 0, 0, 0, 1);
    for (int i = 1; i < 32; i++) begin
      Clr_Req = (i == 15);
      tick();
      chk_out($sformatf("clr%0d", i), 0, 0, 0, 5'(i), 0, 1);
    end
    Clr_Req = 0;
    tick();
    chk_out("clr_exit", 0, 0, 1, 0, 0, 0);
    tick();
    chk_out("clr_ack", 1, 0, 0, 7, 32'h77, 0);
    Req0 = 0;
    tick();
    chk_out("clr_after", 0, 0, 1, 0, 0, 0);

    // Reset asserted between clock edges while the sweep shows address 10.
    Clr_Req = 1;
    tick();
    Clr_Req = 0;
    for (int i = 1; i <= 10; i++) tick();
    chk_out("pre_rst", 0, 0, 0, 10, 0, 1);
    #1;
    Reset = 1;
    #1;
    chk_out("async_rst", 0, 0, 1, 0, 0, 0);
    chk("async_rst.addr", 32'(Rf_W_Addr), 32'd0);
    model_reset();
    @(posedge Clk);
    #1;
    Reset = 0;
    tick();
    chk_out("post_rst0", 0, 0, 1, 0, 0, 0);
    tick();
    chk_out("post_rst1", 0, 0, 1, 0, 0, 0);

    // Randomized traffic against the model, with writes tracked in exp_q.
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      if (m_ack0 || !Req0) begin
        Req0 = ($urandom_range(0, 2) == 0);
        Addr0 = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
        Data0 = $urandom;
      end
      if (m_ack1 || !Req1) begin
        Req1 = ($urandom_range(0, 2) == 0);
        Addr1 = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
        Data1 = $urandom;
      end
      Clr_Req = ($urandom_range(0, 59) == 0);
      tick();
      if (Ack0 !== m_ack0 || Ack1 !== m_ack1 || Rf_We !== m_we || Clr_Busy !== m_busy)
        chk_out($sformatf("rnd%0d", c), m_ack0, m_ack1, m_we, m_addr, m_data, m_busy);
      if (Ack0 && Ack1) chk("rnd.both_ack", 32'd1, 32'd0);
      if (!m_we) exp_q.push_back({m_addr, m_data});
      if (!Rf_We) begin
        if (exp_q.size() == 0) chk("sb.unexpected_write", {27'd0, Rf_W_Addr}, 32'hFFFF_FFFF);
        else begin
          logic [36:0] e;
          e = exp_q.pop_front();
          chk("sb.addr", 32'(Rf_W_Addr), 32'(e[36:32]));
          chk("sb.data", Rf_W_Data, e[31:0]);
        end
      end
    end
    chk("sb.leftover", exp_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/rf_wb_arbiter.md
RF_WB_ARBITER -- requirements
Module: rf_wb_arbiter

Interface
REQ-001 Parameters: none; all widths are fixed at 5-bit register address and 32-bit data.
REQ-002 Clk  input  1  single clock; all state updates on posedge Clk.
REQ-003 Reset  input  1  asynchronous, active-high reset.
REQ-004 Req0  input  1  requester 0 (ALU write-back) write request; held until Ack0.
REQ-005 Addr0  input  5  requester 0 destination register.
REQ-006 Data0  input  32  requester 0 write data.
REQ-007 Ack0  output  1  one-cycle pulse; requester 0 write accepted.
REQ-008 Req1 / Addr1 / Data1 / Ack1  same as REQ-004..007, requester 1 (load write-back).
REQ-009 Clr_Req  input  1  request a full register-file clear sweep.
REQ-010 Clr_Busy  output  1  high while the clear sweep runs.
REQ-011 Rf_W_Addr  output  5  register-file write address.
REQ-012 Rf_W_Data  output  32  register-file write data.
REQ-013 Rf_We  output  1  register-file write enable, active-low (0 = write, 1 = hold).

Function
REQ-014 FSM states: IDLE (no write driven), WRITE (one granted write on outputs), CLEAR (sweep).
REQ-015 All outputs are registered; grant decided in cycle t appears on Rf_*/Ack in cycle t+1 (latency 1).
REQ-016 Eligibility: Req_k high AND Ack_k low in the current cycle; a requester being acked this cycle is not re-granted, preventing double writes of a held request.
REQ-017 In IDLE or WRITE with Clr_Req low, if any requester is eligible, grant one: drive Rf_W_Addr/Rf_W_Data from it, Ack_k=1, go to WRITE; else go to IDLE.
REQ-018 Round-robin: if both are eligible, grant the one not granted last (Last pointer); a single eligible requester is always granted; Last updates on every grant.
REQ-019 Addr_k = 0: request is granted and acked normally, but Rf_We stays 1 (write to register 0 suppressed).
REQ-020 Rf_We = 0 only in WRITE with nonzero address or in CLEAR; otherwise 1. Ack0 and Ack1 are never high together.
REQ-021 Clr_Req high in IDLE or WRITE takes priority over requests: no grant that cycle; next cycle enter CLEAR with Clr_Busy=1, counter=0.
REQ-022 CLEAR: each cycle drive Rf_W_Addr=counter, Rf_W_Data=0, Rf_We=0; counter increments. After address 31 (32 cycles), return to IDLE with Clr_Busy=0 and arbitration resuming that same cycle.
REQ-023 During CLEAR, requests are neither acked nor lost (requesters keep holding), and Clr_Req is ignored.
REQ-024 Counter wraps 31->0 on CLEAR exit; no address above 31 is ever driven.

Reset
REQ-025 Reset asserted (any time, including mid-CLEAR or mid-WRITE) forces IDLE immediately: Ack0=Ack1=0, Rf_We=1, Rf_W_Addr=0, Rf_W_Data=0, Clr_Busy=0, counter=0, Last=1 (requester 0 wins the first tie).
REQ-026 An aborted clear is not resumed after reset release.

Configuration
REQ-027 Macro RF_WB_FIXED_PRIO_EN: when defined, requester 0 always wins ties and Last is unused; when undefined, round-robin per REQ-018.

Verification
REQ-028 Req0 only, Addr0=5, Data0=0x1234_5678 -> next cycle Rf_We=0, Rf_W_Addr=5, Rf_W_Data=0x12345678, Ack0=1; one write only despite Req0 held through the Ack cycle.
REQ-029 Req0 and Req1 held continuously after reset (Addr 3/4) -> grants alternate 0,1,0,1 with one write per cycle (fixed-priority build: Req0 granted every other cycle; Req1 is granted only in the cycles where Req0 is ineligible).
REQ-030 Req1 with Addr1=0 -> Ack1=1, Rf_We stays 1.
REQ-031 Clr_Req pulse while Req0 held -> 32 cycles Rf_We=0, addresses 0..31, data 0, Clr_Busy=1, Ack0 low; Ack0 occurs the cycle after Clr_Busy falls.
REQ-032 Reset asserted at clear address 10 -> outputs at reset values asynchronously; after release, IDLE with Clr_Busy=0.
